// File: rtl/intra_pkg.sv
// Shared types and default geometry for the intra tile scheduler.
package intra_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int DEF_FRAME_W = 1280;
  localparam int DEF_FRAME_H = 720;
  localparam int DEF_STEP_X  = 4;
  localparam int DEF_STEP_Y  = 8;
  localparam int COORD_W     = 16;

endpackage

// File: rtl/intra_tile_scheduler_if.sv
// Control and engine handshake bundle between the scheduler and its two tile engines.
interface intra_tile_scheduler_if;
  import intra_pkg::*;

  logic               start;
  logic [1:0]         eng_start;
  logic [COORD_W-1:0] eng0_x;
  logic [COORD_W-1:0] eng0_y;
  logic [COORD_W-1:0] eng1_x;
  logic [COORD_W-1:0] eng1_y;
  logic [1:0]         eng_done;
  logic               busy;
  logic               done;
  logic               err;

  modport slave (
    input  start, eng_done,
    output eng_start, eng0_x, eng0_y, eng1_x, eng1_y, busy, done, err
  );

  modport master (
    output start, eng_done,
    input  eng_start, eng0_x, eng0_y, eng1_x, eng1_y, busy, done, err
  );
endinterface

// File: rtl/tile_coord_gen.sv
// Raster tile coordinate counter: steps x by STEP_X, wraps to the next row, flags the final tile.
module tile_coord_gen
  import intra_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int STEP_X  = DEF_STEP_X,
  parameter int STEP_Y  = DEF_STEP_Y
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               next,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(FRAME_W - STEP_X);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(FRAME_H - STEP_Y);
  localparam logic [COORD_W-1:0] INC_X  = COORD_W'(STEP_X);
  localparam logic [COORD_W-1:0] INC_Y  = COORD_W'(STEP_Y);

  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;

  // Coordinate register: load returns to the frame origin, next advances one tile.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_r <= 16'd0;
      y_r <= 16'd0;
    end else if (load) begin
      x_r <= 16'd0;
      y_r <= 16'd0;
    end else if (next) begin
      if (x_r == LAST_X) begin
        x_r <= 16'd0;
        y_r <= (y_r == LAST_Y) ? 16'd0 : y_r + INC_Y;
      end else begin
        x_r <= x_r + INC_X;
      end
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = (x_r == LAST_X) && (y_r == LAST_Y);

endmodule

// File: rtl/intra_tile_scheduler.sv
// Hands raster-ordered tiles of one frame to two engines, round-robin, with protocol error tracking.
module intra_tile_scheduler
  import intra_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int STEP_X  = DEF_STEP_X,
  parameter int STEP_Y  = DEF_STEP_Y
) (
  input  logic                   clk,
  input  logic                   reset,
  intra_tile_scheduler_if.slave  bus
);

  state_t             state_r, state_s;
  logic [1:0]         eng_busy_r;
  logic               rr_r;
  logic [1:0]         eng_start_r;
  logic [COORD_W-1:0] eng0_x_r, eng0_y_r, eng1_x_r, eng1_y_r;
  logic               busy_r, done_r, err_r;

  logic [1:0]         grant_s;
  logic [1:0]         done_valid_s;
  logic               issue_s, accept_s, start_err_s, stray_s, last_s;
  logic [COORD_W-1:0] coord_x_s, coord_y_s;

  assign done_valid_s = bus.eng_done & eng_busy_r;
  assign accept_s     = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign start_err_s  = bus.start && ((state_r == ST_DISPATCH) || (state_r == ST_DRAIN));
  // A stray completion in IDLE belongs to a pass abandoned by reset and is not an error.
  assign stray_s      = (|(bus.eng_done & ~eng_busy_r)) && (state_r != ST_IDLE);
  assign issue_s      = |grant_s;

  tile_coord_gen #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .STEP_X  (STEP_X),
    .STEP_Y  (STEP_Y)
  ) u_coord (
    .clk   (clk),
    .reset (reset),
    .load  (accept_s),
    .next  (issue_s),
    .x     (coord_x_s),
    .y     (coord_y_s),
    .last  (last_s)
  );

  // Engine grant: only idle engines in DISPATCH, pointer breaks the tie.
  always_comb begin
    grant_s = 2'b00;
    if (state_r == ST_DISPATCH) begin
      case (~eng_busy_r)
        2'b11:   grant_s = rr_r ? 2'b10 : 2'b01;
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // Next-state logic of the frame pass.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) state_s = ST_DISPATCH;
        else          state_s = state_r;
      end
      ST_DISPATCH: begin
        if (issue_s && last_s) state_s = ST_DRAIN;
        else                   state_s = ST_DISPATCH;
      end
      ST_DRAIN: begin
        if (eng_busy_r == 2'b00) state_s = ST_DONE;
        else                     state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, engine tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      eng_busy_r  <= 2'b00;
      rr_r        <= 1'b0;
      eng_start_r <= 2'b00;
      eng0_x_r    <= 16'd0;
      eng0_y_r    <= 16'd0;
      eng1_x_r    <= 16'd0;
      eng1_y_r    <= 16'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      eng_start_r <= grant_s;
      eng_busy_r  <= (eng_busy_r | grant_s) & ~done_valid_s;
      busy_r      <= (state_s == ST_DISPATCH) || (state_s == ST_DRAIN);
      done_r      <= (state_s == ST_DONE);
      if (issue_s) rr_r <= ~rr_r;
      if (grant_s[0]) begin
        eng0_x_r <= coord_x_s;
        eng0_y_r <= coord_y_s;
      end
      if (grant_s[1]) begin
        eng1_x_r <= coord_x_s;
        eng1_y_r <= coord_y_s;
      end
      if (accept_s)                    err_r <= 1'b0;
      else if (start_err_s || stray_s) err_r <= 1'b1;
    end
  end

  assign bus.eng_start = eng_start_r;
  assign bus.eng0_x    = eng0_x_r;
  assign bus.eng0_y    = eng0_y_r;
  assign bus.eng1_x    = eng1_x_r;
  assign bus.eng1_y    = eng1_y_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule
